// File: rtl/zeroparity_accum_pkg.sv
// Shared definitions for the zeroparity gate, its multi-byte accumulator and their benches.
package zeroparity_accum_pkg;

  localparam logic MODE_NONZERO = 1'b0;
  localparam logic MODE_PARITY  = 1'b1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // One fold step of the operand-wide flag: OR for nonzero, XOR for parity.
  function automatic logic fold_bit(input logic mode, input logic acc, input logic q);
    return (mode == MODE_PARITY) ? (acc ^ q) : (acc | q);
  endfunction

endpackage

// File: rtl/zeroparity_accum_modcounter.sv
// Wrap-at-N up-counter with enable, synchronous clear and terminal-count flag.
module modcounter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == W'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/zeroparity_accum.sv
// Folds NBYTES per-byte zeroparity results into one operand-wide zero/parity flag.
module zeroparity_accum
  import zeroparity_accum_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_q,
  input  logic in_mode,
  output logic out_valid,
  input  logic out_ready,
  output logic out_flag,
  output logic out_mode,
  output logic out_err
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e        state_q, state_d;
  logic          acc_q, acc_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic          flag_q, flag_d;
  logic          omode_q, omode_d;
  logic          oerr_q, oerr_d;
  logic [CW-1:0] cnt;
  logic          last;
  logic          accept, first, done;
  logic          fold, fold_mode, fold_err;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid | out_ready;
  assign out_flag  = flag_q;
  assign out_mode  = omode_q;
  assign out_err   = oerr_q;

  // clear wins over a beat presented in the same cycle
  assign accept = in_valid & in_ready & !clear;
  assign first  = (cnt == '0);
  assign done   = accept & last;

  modcounter #(.N(NBYTES), .W(CW)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .clr  (clear),
    .cnt  (cnt),
    .tc   (last)
  );

  // Later bytes fold with the mode latched from byte 0, not the incoming one.
  always_comb begin
    fold_mode = first ? in_mode : mode_q;
    fold      = first ? in_q : fold_bit(mode_q, acc_q, in_q);
    fold_err  = first ? 1'b0 : (err_q | (in_mode != mode_q));
  end

  always_comb begin
    acc_d   = acc_q;
    mode_d  = mode_q;
    err_d   = err_q;
    flag_d  = flag_q;
    omode_d = omode_q;
    oerr_d  = oerr_q;
    state_d = state_q;
    if (accept) begin
      acc_d  = fold;
      mode_d = fold_mode;
      err_d  = fold_err;
    end
    if (done) begin
      flag_d  = fold;
      omode_d = fold_mode;
      oerr_d  = fold_err;
      state_d = ST_FULL;
    end else if (out_valid && out_ready) begin
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= 1'b0;
      mode_q  <= MODE_NONZERO;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
      omode_q <= MODE_NONZERO;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      omode_q <= omode_d;
      oerr_q  <= oerr_d;
    end
  end

endmodule

// File: tb/tb_zeroparity_accum.sv
// Bench for zeroparity_accum: instances with NBYTES=2,3,1, an operand-level model and directed vectors.
module tb_zeroparity_accum;

  logic       clk;
  logic       rst_n;
  logic [2:0] clear, in_valid, in_q, in_mode, out_ready;
  logic [2:0] in_ready, out_valid, out_flag, out_mode, out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    zeroparity_accum #(.NBYTES(g == 0 ? 2 : (g == 1 ? 3 : 1))) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_q     (in_q[g]),
      .in_mode  (in_mode[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_flag (out_flag[g]),
      .out_mode (out_mode[g]),
      .out_err  (out_err[g])
    );
  end

  function automatic int nb(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Operand-level model: collect accepted bytes, fold the whole operand once it is complete.
  bit mq [3][16];
  bit mm [3][16];
  int mc [3];
  bit ev [3];
  bit ef [3];
  bit emo[3];
  bit eer[3];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) begin
          mc[k] = 0; ev[k] = 0; ef[k] = 0; emo[k] = 0; eer[k] = 0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          bit take, f, e;
          take = in_valid[k] && (!ev[k] || out_ready[k]) && !clear[k];
          if (ev[k] && out_ready[k]) ev[k] = 0;
          if (clear[k]) mc[k] = 0;
          if (take) begin
            mq[k][mc[k]] = in_q[k];
            mm[k][mc[k]] = in_mode[k];
            mc[k]++;
            if (mc[k] == nb(k)) begin
              f = mq[k][0];
              e = 0;
              for (int i = 1; i < nb(k); i++) begin
                f = mm[k][0] ? (f ^ mq[k][i]) : (f | mq[k][i]);
                e = e | (mm[k][i] != mm[k][0]);
              end
              ev[k] = 1; ef[k] = f; emo[k] = mm[k][0]; eer[k] = e; mc[k] = 0;
            end
          end
        end
      end
    end
  end

  // Every cycle out of reset: DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("u%0d.in_ready", k), in_ready[k], !ev[k] | out_ready[k]);
          chk($sformatf("u%0d.out_valid", k), out_valid[k], ev[k]);
          if (ev[k]) begin
            chk($sformatf("u%0d.out_flag", k), out_flag[k], ef[k]);
            chk($sformatf("u%0d.out_mode", k), out_mode[k], emo[k]);
            chk($sformatf("u%0d.out_err", k), out_err[k], eer[k]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic beat(input int k, input logic q, input logic m);
    in_valid[k] = 1'b1;
    in_q[k]     = q;
    in_mode[k]  = m;
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic res(input string tag, input int k, input logic v, input logic f,
                     input logic m, input logic e);
    chk({tag, ".valid"}, out_valid[k], v);
    chk({tag, ".flag"}, out_flag[k], f);
    chk({tag, ".mode"}, out_mode[k], m);
    chk({tag, ".err"}, out_err[k], e);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = '0;
    in_valid  = '0;
    in_q      = '0;
    in_mode   = '0;
    out_ready = '1;
    #12;
    for (int k = 0; k < 3; k++) begin
      res($sformatf("reset%0d", k), k, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("reset%0d.in_ready", k), in_ready[k], 1'b1);
    end
    rst_n = 1'b1;
    tick();

    // nonzero mode
    beat(0, 0, 0); beat(0, 0, 0);
    res("nz00", 0, 1, 0, 0, 0);
    beat(0, 0, 0); beat(0, 1, 0);
    res("nz01", 0, 1, 1, 0, 0);

    // parity mode, result visible right after the second beat
    beat(0, 1, 1);
    chk("par11.valid_early", out_valid[0], 1'b0);
    beat(0, 1, 1);
    res("par11", 0, 1, 0, 1, 0);
    beat(0, 1, 1);
    chk("par10.valid_early", out_valid[0], 1'b0);
    beat(0, 0, 1);
    res("par10", 0, 1, 1, 1, 0);

    // mode mismatch folds with byte 0's mode
    beat(0, 1, 1); beat(0, 1, 0);
    res("mism", 0, 1, 0, 1, 1);

    // backpressure: held result stable, input stalled
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; in_q[0] = 1'b1; in_mode[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.in_ready", in_ready[0], 1'b0);
      res("bp", 0, 1, 0, 1, 1);
    end
    out_ready[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    chk("bp.release_valid", out_valid[0], 1'b0);
    beat(0, 0, 0);
    res("bp.next", 0, 1, 1, 0, 0);

    // clear after byte 0 discards it
    beat(0, 1, 0);
    clear[0] = 1'b1; tick(); clear[0] = 1'b0;
    chk("clr.valid", out_valid[0], 1'b0);
    beat(0, 0, 0);
    chk("clr.byte0_valid", out_valid[0], 1'b0);
    beat(0, 0, 0);
    res("clr", 0, 1, 0, 0, 0);

    // clear while FULL leaves the held result alone
    out_ready[0] = 1'b0;
    clear[0] = 1'b1; tick(); clear[0] = 1'b0;
    res("clr_full", 0, 1, 0, 0, 0);
    out_ready[0] = 1'b1;

    // beat accepted with clear is dropped
    clear[0] = 1'b1; beat(0, 1, 0); clear[0] = 1'b0;
    beat(0, 0, 0);
    chk("clrbeat.byte0_valid", out_valid[0], 1'b0);
    beat(0, 0, 0);
    res("clrbeat", 0, 1, 0, 0, 0);

    // async reset between edges clears a held result at once
    beat(0, 1, 0); beat(0, 1, 0);
    res("pre_rst", 0, 1, 1, 0, 0);
    out_ready[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    res("rst_held", 0, 0, 0, 0, 0);
    chk("rst_held.in_ready", in_ready[0], 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    out_ready[0] = 1'b1;

    // async reset mid-operand drops the partial byte
    beat(0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    res("rst_mid", 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    beat(0, 0, 0);
    chk("rst_fresh.byte0_valid", out_valid[0], 1'b0);
    beat(0, 0, 0);
    res("rst_fresh", 0, 1, 0, 0, 0);

    // NBYTES=1: every beat is an operand
    beat(2, 1, 1);
    res("nb1.a", 2, 1, 1, 1, 0);
    beat(2, 0, 0);
    res("nb1.b", 2, 1, 0, 0, 0);
    beat(2, 1, 0);
    res("nb1.c", 2, 1, 1, 0, 0);

    // NBYTES=3: every q x mode combination over three beats
    for (int c = 0; c < 64; c++) begin
      logic f, e;
      f = c[1] ? (c[0] ^ c[2] ^ c[4]) : (c[0] | c[2] | c[4]);
      e = (c[3] != c[1]) | (c[5] != c[1]);
      beat(1, c[0], c[1]);
      beat(1, c[2], c[3]);
      beat(1, c[4], c[5]);
      res($sformatf("nb3.%0d", c), 1, 1'b1, f, c[1], e);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
